// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the instruction-cache refill sequencer.
package icache_pkg;

    localparam int ADDR_W = 20;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOOKUP = 3'd1;
    localparam state_t S_CHECK  = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_FILL   = 3'd4;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Fetch-side sequencer: icache lookup, and on a miss a memory read that is
// filled into the icache and bypassed to the fetch stage in the same cycle.
//
//   state  | meaning
//   IDLE   | waiting for if_req; a misaligned request gives a one-cycle if_err
//   LOOKUP | icache read in flight for LOOKUP_LAT cycles
//   CHECK  | icache result valid: hit returns the word, miss goes to MEM
//   MEM    | mem_req held until mem_ack or MEM_TMO cycles without one
//   FILL   | one-cycle icache write with the memory word, forwarded to fetch
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int LOOKUP_LAT = 2,
    parameter int MEM_TMO    = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_busy,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic              if_err,
    output logic              ic_read_en,
    output logic              ic_fetch,
    output logic [ADDR_W-1:0] ic_read_addr,
    output logic [ADDR_W-1:0] ic_write_addr,
    output logic [WORD_W-1:0] ic_write_data,
    input  logic              ic_miss,
    input  logic [WORD_W-1:0] ic_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LOOKUP_LAT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_a;
    logic [WORD_W-1:0] r_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_pend;
    logic              w_req_seen;
    logic              w_accept;
    logic              w_misalign;
    logic              w_tmo;

    // The cycle carrying if_err ignores if_req so a held misaligned request
    // cannot retrigger before the fetch stage has seen the error.
    assign w_req_seen = if_req && !r_err_pend;
    assign w_accept   = w_req_seen && (if_addr[1:0] == 2'b00);
    assign w_misalign = w_req_seen && (if_addr[1:0] != 2'b00);
    assign w_tmo      = (r_cnt >= TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_cnt == LAT_LAST) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = ic_miss ? S_MEM : S_IDLE;
            end
            S_MEM: begin
                if (mem_ack) begin
                    w_state_nxt = S_FILL;
                end else if (w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a        <= '0;
            r_d        <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= (r_state == S_IDLE) && w_misalign;
            if ((r_state == S_IDLE) && w_accept) begin
                r_a <= if_addr;
            end
            if ((r_state == S_MEM) && mem_ack) begin
                r_d <= mem_rdata;
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        if_valid   = 1'b0;
        if_instr   = '0;
        if_err     = 1'b0;
        ic_read_en = 1'b0;
        ic_fetch   = 1'b0;
        mem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if_err = r_err_pend;
            end
            S_LOOKUP: begin
                ic_read_en = 1'b1;
            end
            S_CHECK: begin
                ic_read_en = 1'b1;
                if (!ic_miss) begin
                    if_valid = 1'b1;
                    if_instr = ic_rdata;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (w_tmo && !mem_ack) if_err = 1'b1;
            end
            S_FILL: begin
                ic_fetch = 1'b1;
                if_valid = 1'b1;
                if_instr = r_d;
            end
            default: begin
                if_valid = 1'b0;
            end
        endcase
    end

    assign if_busy       = (r_state != S_IDLE);
    assign ic_read_addr  = r_a;
    assign ic_write_addr = r_a;
    assign ic_write_data = r_d;
    assign mem_addr      = r_a;

endmodule
